arb2_stream: RTL and testbench
==============================

Name: arb2_stream

Overview:
Two-input packet-aware round-robin arbiter with valid/ready handshakes on every stream. It sits directly upstream of the mux2 datapath and owns the sel decision. Internally it steers data through a mux2 instance and registers the result into a single output stage. It yields one beat per cycle, packets are never interleaved, and the two sources get fair access.

Parameters:
WIDTH, 16, data width of both input streams and the output stream
STAT_WIDTH, 16, width of per-input grant counters (used only with ARB2_STATS_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_1_data  input  WIDTH  source 1 payload
in_1_valid  input  1  source 1 beat available
in_1_last  input  1  source 1 final beat of packet
in_1_ready  output  1  source 1 beat accepted this cycle when high with in_1_valid
in_2_data  input  WIDTH  source 2 payload
in_2_valid  input  1  source 2 beat available
in_2_last  input  1  source 2 final beat of packet
in_2_ready  output  1  source 2 beat accepted this cycle when high with in_2_valid
out_data  output  WIDTH  registered payload
out_last  output  1  registered last flag
out_valid  output  1  output beat held
out_ready  input  1  downstream accepts
sel  output  1  registered; 0 = last accepted beat came from in_1, 1 = from in_2
cnt_1  output  STAT_WIDTH  accepted packets from in_1 (ARB2_STATS_EN only)
cnt_2  output  STAT_WIDTH  accepted packets from in_2 (ARB2_STATS_EN only)

Behaviour:
- Reset (rst high at clk edge): out_valid=0, out_data=0, out_last=0, sel=0, state=IDLE, prio=0 (in_1 preferred), cnt_1=cnt_2=0.
- load = !out_valid || out_ready. This is combinational, giving full throughput with no bubble under continuous out_ready.
- FSM states:
  - IDLE: no packet open. grant = the sole valid input. If both inputs are valid, grant = in_1 when prio=0, else in_2.
  - LOCK_1: packet from in_1 open. Only in_1 may be granted; in_2_ready=0.
  - LOCK_2: packet from in_2 open. Only in_2 may be granted; in_1_ready=0.
- in_n_ready = load && grant==n. Ready may depend on both valids (IDLE only). It is 0 when no grant is made.
- On accept from input n:
  - out_data <= in_n_data, out_last <= in_n_last, out_valid <= 1, sel <= n-1. The data path goes through the mux2 instance, which is driven by the combinational grant.
  - last=0: state <= LOCK_n.
  - last=1: state <= IDLE, prio <= other input.
  - A single-beat packet in IDLE goes straight back to IDLE and prio flips.
- No accept and out_ready=1: out_valid <= 0. out_data, out_last and sel hold.
- out_valid=1 and out_ready=0: all outputs hold, both readys are 0, and the FSM and prio do not change.
- Latency: input accept to out_valid is 1 cycle.
- In LOCK_n with in_n_valid=0: wait, do not switch sources, no timeout.
- Mid-packet reset: the lock is dropped and the output register is cleared. Discarding the rest of the packet is the upstream's job.
- Grant decisions never look at out_ready except through load.

Optional Feature:
ARB2_STATS_EN
- Defined:
  - cnt_1 and cnt_2 ports exist.
  - Each counter increments by 1 on acceptance of a beat with last=1 from its input.
  - Counters saturate at all-ones and do not wrap.
  - Counters are cleared by rst.
- Undefined: cnt ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package arb2_pkg holds:
  - the state enum {IDLE, LOCK_1, LOCK_2}, 2-bit encoding;
  - localparams SEL_IN_1=1'b0 and SEL_IN_2=1'b1, also used for prio.
- Sub-module: the existing mux2 (parameter WIDTH, ports in_1, in_2, sel, out) instantiated once for payload selection. in_n_last is selected alongside it with plain logic.
- The FSM, prio and output register stay in arb2_stream.

Test Plan:
1. After reset, both sources send single-beat packets continuously (in_1_data=16'h00ad, in_2_data=16'hbeef, last=1, out_ready=1) -> output alternates 00ad, beef, 00ad...; sel toggles 0,1,0; 1-cycle latency; no idle cycles.
2. in_1 sends a 3-beat packet (16'h0001,0002,0003 with last on the third) while in_2 holds a single-beat packet valid -> in_2_ready stays 0 for all three beats; in_2's beat appears on the 4th output cycle.
3. Backpressure: out_ready=0 for 4 cycles while out_valid=1 -> out_data, out_last and sel are stable, both readys are 0; the first cycle out_ready=1 accepts the next beat.
4. in_1 holds LOCK_1 with in_1_valid low for 5 cycles while in_2 is valid -> no in_2 grant; in_1 resumes with its last beat, then in_2 is granted next.
5. rst asserted on the 2nd beat of a 3-beat in_2 packet -> next cycle out_valid=0, sel=0, state IDLE; with both valid afterwards, in_1 wins first.
6. ARB2_STATS_EN: 5 in_1 packets and 3 in_2 packets -> cnt_1=5, cnt_2=3. With STAT_WIDTH=2 and 5 in_1 packets -> cnt_1 saturates at 3.

Source files
------------

// File: rtl/arb2_pkg.sv
// arb2_pkg: state encoding and source selectors shared by arb2_stream and mux2
package arb2_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK_1 = 2'd1, LOCK_2 = 2'd2} state_t;
  localparam logic SEL_IN_1 = 1'b0;
  localparam logic SEL_IN_2 = 1'b1;
endpackage

// File: rtl/arb2_stream_mux2.sv
// mux2: two-way payload selector steered by the arbiter grant
module mux2
  import arb2_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = (sel == SEL_IN_2) ? in_2 : in_1;
endmodule

// File: rtl/arb2_stream.sv
// arb2_stream: packet-aware 2-input round-robin arbiter with a registered output stage; ARB2_STATS_EN adds saturating per-source packet counters
module arb2_stream
  import arb2_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_1_data,
  input  logic             in_1_valid,
  input  logic             in_1_last,
  output logic             in_1_ready,
  input  logic [WIDTH-1:0] in_2_data,
  input  logic             in_2_valid,
  input  logic             in_2_last,
  output logic             in_2_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
`ifdef ARB2_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] cnt_1,
  output logic [STAT_WIDTH-1:0] cnt_2
`endif
);
  state_t           r_state, w_state_nxt;
  logic             r_prio, r_out_valid, r_out_last, r_sel;
  logic [WIDTH-1:0] r_out_data, w_data;
  logic             w_load, w_gnt, w_gnt_valid, w_acc, w_last;

  if (STAT_WIDTH < 1) begin : g_bad_stat_width
    $error("STAT_WIDTH must be at least 1");
  end

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .in_1(in_1_data),
    .in_2(in_2_data),
    .sel (w_gnt),
    .out (w_data)
  );

  // grant: an open packet keeps its source, otherwise the sole requester or prio on a tie
  always_comb begin
    w_load      = !r_out_valid || out_ready;
    w_gnt       = r_state == LOCK_1 ? SEL_IN_1 :
                  r_state == LOCK_2 ? SEL_IN_2 :
                  (in_1_valid && in_2_valid) ? r_prio :
                  (in_2_valid ? SEL_IN_2 : SEL_IN_1);
    w_gnt_valid = (w_gnt == SEL_IN_2) ? in_2_valid : in_1_valid;
    w_acc       = w_load && w_gnt_valid;
    w_last      = (w_gnt == SEL_IN_2) ? in_2_last : in_1_last;
    w_state_nxt = !w_acc ? r_state : w_last ? IDLE : (w_gnt == SEL_IN_2 ? LOCK_2 : LOCK_1);
    in_1_ready  = w_acc && w_gnt == SEL_IN_1;
    in_2_ready  = w_acc && w_gnt == SEL_IN_2;
  end

  // packet lock state and round-robin priority, flipped when a packet closes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= SEL_IN_1;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && w_last) r_prio <= !w_gnt;
    end
  end

  // output stage: load on accept, drop valid once drained, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sel       <= SEL_IN_1;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_sel       <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sel       = r_sel;

`ifdef ARB2_STATS_EN
  logic [STAT_WIDTH-1:0] r_cnt_1, r_cnt_2;

  // completed-packet counters per source, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
    end else if (w_acc && w_last) begin
      if (w_gnt == SEL_IN_1 && r_cnt_1 != '1) r_cnt_1 <= r_cnt_1 + 1'b1;
      if (w_gnt == SEL_IN_2 && r_cnt_2 != '1) r_cnt_2 <= r_cnt_2 + 1'b1;
    end
  end

  assign cnt_1 = r_cnt_1;
  assign cnt_2 = r_cnt_2;
`endif
endmodule

// File: tb/tb_arb2_stream.sv
// tb_arb2_stream: scoreboard bench for arb2_stream; ARB2_STATS_EN also checks the packet counters
module tb_arb2_stream;
  typedef struct {logic [15:0] d; logic l;} beat_t;
  typedef struct {logic [15:0] d; logic l; logic s;} out_t;

  logic        clk = 1'b0;
  logic        rst, out_ready;
  logic [15:0] in_1_data, in_2_data, out_data;
  logic        in_1_valid, in_1_last, in_1_ready;
  logic        in_2_valid, in_2_last, in_2_ready;
  logic        out_last, out_valid, sel;

  beat_t q1[$], q2[$];
  out_t  exp_q[$];
  out_t  e;
  int    n_tot = 0, n_bad = 0, cyc;
  bit    h1, h2, rs;

  always #5 clk = ~clk;

`ifdef ARB2_STATS_EN
  logic [15:0] cnt_1, cnt_2;
  logic [1:0]  sat_cnt_1, sat_cnt_2;
  logic [15:0] sat_data;
  logic        sat_r1, sat_r2, sat_last, sat_valid, sat_sel;
`endif

  arb2_stream #(.WIDTH(16), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_1_data(in_1_data), .in_1_valid(in_1_valid), .in_1_last(in_1_last), .in_1_ready(in_1_ready),
    .in_2_data(in_2_data), .in_2_valid(in_2_valid), .in_2_last(in_2_last), .in_2_ready(in_2_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel)
`ifdef ARB2_STATS_EN
    , .cnt_1(cnt_1), .cnt_2(cnt_2)
`endif
  );

`ifdef ARB2_STATS_EN
  arb2_stream #(.WIDTH(16), .STAT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_1_data(in_1_data), .in_1_valid(in_1_valid), .in_1_last(in_1_last), .in_1_ready(sat_r1),
    .in_2_data(in_2_data), .in_2_valid(in_2_valid), .in_2_last(in_2_last), .in_2_ready(sat_r2),
    .out_data(sat_data), .out_last(sat_last), .out_valid(sat_valid), .out_ready(out_ready),
    .sel(sat_sel), .cnt_1(sat_cnt_1), .cnt_2(sat_cnt_2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [15:0] d, input logic l);
    q1.push_back('{d: d, l: l});
  endtask

  task automatic push2(input logic [15:0] d, input logic l);
    q2.push_back('{d: d, l: l});
  endtask

  task automatic exp_push(input logic [15:0] d, input logic l, input logic s);
    exp_q.push_back('{d: d, l: l, s: s});
  endtask

  task automatic drain(input string tag, input bit no_g2, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
      if (no_g2 && q1.size() != 0) chk({tag, "_rdy2"}, 32'(in_2_ready), 0);
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // sources: a beat leaves its queue when valid&&ready held at a non-reset edge
  initial begin
    in_1_valid = 1'b0; in_1_data = '0; in_1_last = 1'b0;
    in_2_valid = 1'b0; in_2_data = '0; in_2_last = 1'b0;
    forever begin
      @(negedge clk);
      h1 = in_1_valid && in_1_ready;
      h2 = in_2_valid && in_2_ready;
      @(posedge clk);
      rs = rst;
      #1;
      if (!rs && h1 && q1.size() != 0) void'(q1.pop_front());
      if (!rs && h2 && q2.size() != 0) void'(q2.pop_front());
      in_1_valid = q1.size() != 0;
      in_1_data  = q1.size() != 0 ? q1[0].d : '0;
      in_1_last  = q1.size() != 0 ? q1[0].l : 1'b0;
      in_2_valid = q2.size() != 0;
      in_2_data  = q2.size() != 0 ? q2[0].d : '0;
      in_2_last  = q2.size() != 0 ? q2[0].l : 1'b0;
    end
  end

  // output monitor: every consumed output beat is compared with the scoreboard head
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {16'h0, out_data}, 32'hffff_ffff);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
        chk("out_sel", 32'(sel), 32'(e.s));
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_sel", 32'(sel), 0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      push1(16'h00ad, 1'b1); push2(16'hbeef, 1'b1);
      exp_push(16'h00ad, 1'b1, 1'b0); exp_push(16'hbeef, 1'b1, 1'b1);
    end
    drain("t1", 1'b0, cyc);
    chk("t1_cycles", cyc, 8);

    push1(16'h0001, 1'b0); push1(16'h0002, 1'b0); push1(16'h0003, 1'b1);
    push2(16'h2222, 1'b1);
    exp_push(16'h0001, 1'b0, 1'b0); exp_push(16'h0002, 1'b0, 1'b0);
    exp_push(16'h0003, 1'b1, 1'b0); exp_push(16'h2222, 1'b1, 1'b1);
    drain("t2", 1'b1, cyc);

    push1(16'h0033, 1'b1); push2(16'h0044, 1'b1);
    exp_push(16'h0033, 1'b1, 1'b0); exp_push(16'h0044, 1'b1, 1'b1);
    repeat (2) tick();
    out_ready = 1'b0;
    repeat (4) begin
      tick();
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_data", 32'(out_data), 32'h0033);
      chk("t3_last", 32'(out_last), 1);
      chk("t3_sel", 32'(sel), 0);
      chk("t3_rdy1", 32'(in_1_ready), 0);
      chk("t3_rdy2", 32'(in_2_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_resume_rdy2", 32'(in_2_ready), 1);
    drain("t3", 1'b0, cyc);

    push1(16'h0041, 1'b0); push2(16'h0051, 1'b1);
    exp_push(16'h0041, 1'b0, 1'b0); exp_push(16'h0042, 1'b1, 1'b0); exp_push(16'h0051, 1'b1, 1'b1);
    repeat (2) tick();
    repeat (5) begin
      tick();
      chk("t4_lock_rdy2", 32'(in_2_ready), 0);
    end
    push1(16'h0042, 1'b1);
    drain("t4", 1'b0, cyc);

    push2(16'h0061, 1'b0); push2(16'h0062, 1'b0); push2(16'h0063, 1'b1);
    exp_push(16'h0061, 1'b0, 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    q2.delete();
    tick();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_sel", 32'(sel), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_last", 32'(out_last), 0);
    rst = 1'b0;
    push1(16'h0071, 1'b1); push2(16'h0072, 1'b1);
    exp_push(16'h0071, 1'b1, 1'b0); exp_push(16'h0072, 1'b1, 1'b1);
    drain("t5", 1'b0, cyc);

`ifdef ARB2_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push1(16'h00a1, 1'b1);
    for (int i = 0; i < 3; i++) push2(16'h00b2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1 && i < 6) exp_push(16'h00b2, 1'b1, 1'b1);
      else exp_push(16'h00a1, 1'b1, 1'b0);
    end
    drain("t6", 1'b0, cyc);
    tick();
    chk("t6_cnt_1", 32'(cnt_1), 5);
    chk("t6_cnt_2", 32'(cnt_2), 3);
    chk("t6_sat_cnt_1", 32'(sat_cnt_1), 3);
    chk("t6_sat_cnt_2", 32'(sat_cnt_2), 3);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
